alu_op_sequencer: RTL and testbench

- Initiator-side controller for the team's combinational 16-bit-in / 15-bit-out ALU.
- Accepts operation requests over a valid/ready handshake and drives the ALU `command`/`A`/`B` inputs.
- For two-part operations (multiply high/low, divide quotient/remainder) it issues both ALU commands in sequence, captures each 15-bit result, and returns one combined response over a second valid/ready handshake.
- Sits between the datapath control and the ALU instance.

---
 rtl/alu_op_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Initiator-side sequencer for the 16-in/15-out combinational ALU: one request in, one combined response out.
// Optional build macro ALU_SEQ_PERF_CNT_EN adds a 16-bit op_count response counter port.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [2:0]  alu_command,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [14:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [14:0] rsp_hi,
  output logic [14:0] rsp_lo,
`ifdef ALU_SEQ_PERF_CNT_EN
  output logic [15:0] op_count,
`endif
  output logic        rsp_err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RES_W  = 15;
  localparam int unsigned CMD_W  = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CMD_W-1:0] OP_ADD = 3'd0;
  localparam logic [CMD_W-1:0] OP_SUB = 3'd1;
  localparam logic [CMD_W-1:0] OP_AND = 3'd2;
  localparam logic [CMD_W-1:0] OP_MUL = 3'd3;
  localparam logic [CMD_W-1:0] OP_DIV = 3'd4;

  localparam logic [CMD_W-1:0] CMD_IDLE   = 3'd0;
  localparam logic [CMD_W-1:0] CMD_MUL_HI = 3'd3;
  localparam logic [CMD_W-1:0] CMD_MUL_LO = 3'd4;
  localparam logic [CMD_W-1:0] CMD_DIV_Q  = 3'd5;
  localparam logic [CMD_W-1:0] CMD_DIV_R  = 3'd6;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE1 = 2'd1,
    ISSUE2 = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CMD_W-1:0]   op_q, op_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [RES_W-1:0]   hi_q, hi_d;
  logic [RES_W-1:0]   lo_q, lo_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               two_part;
  logic               settle_done;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [DATA_W-1:0]  op_cnt_q, op_cnt_d;
`endif

  assign two_part    = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign settle_done = (cnt_q == SETTLE_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cmd_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef ALU_SEQ_PERF_CNT_EN
      op_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cmd_q    <= cmd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`ifdef ALU_SEQ_PERF_CNT_EN
      op_cnt_q <= op_cnt_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cmd_d    = cmd_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
`ifdef ALU_SEQ_PERF_CNT_EN
    op_cnt_d = op_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          hi_d  = '0;
          lo_d  = '0;
          err_d = 1'b0;
          cnt_d = '0;
          unique case (req_op)
            OP_ADD, OP_SUB, OP_AND: begin
              cmd_d   = req_op;
              state_d = ISSUE1;
            end
            OP_MUL: begin
              cmd_d   = CMD_MUL_HI;
              state_d = ISSUE1;
            end
            OP_DIV: begin
              // Divisors 0 and 1 are rejected up front without touching the ALU
              if (req_b[DATA_W-1:1] == '0) begin
                cmd_d   = CMD_IDLE;
                err_d   = 1'b1;
                state_d = RESP;
              end else begin
                cmd_d   = CMD_DIV_Q;
                state_d = ISSUE1;
              end
            end
            default: begin
              cmd_d   = CMD_IDLE;
              err_d   = 1'b1;
              state_d = RESP;
            end
          endcase
        end
      end

      ISSUE1: begin
        if (settle_done) begin
          cnt_d = '0;
          if (two_part) begin
            hi_d    = alu_result;
            cmd_d   = (op_q == OP_MUL) ? CMD_MUL_LO : CMD_DIV_R;
            state_d = ISSUE2;
          end else begin
            lo_d    = alu_result;
            cmd_d   = CMD_IDLE;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ISSUE2: begin
        if (settle_done) begin
          cnt_d   = '0;
          lo_d    = alu_result;
          cmd_d   = CMD_IDLE;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d  = IDLE;
`ifdef ALU_SEQ_PERF_CNT_EN
          op_cnt_d = op_cnt_q + DATA_W'(1);
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign alu_command = cmd_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp_hi      = hi_q;
  assign rsp_lo      = lo_q;
  assign rsp_err     = err_q;
`ifdef ALU_SEQ_PERF_CNT_EN
  assign op_count    = op_cnt_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a scoreboard of expected responses and a {command, A[11:0]} ALU stub.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [2:0]  req_op1, alu_command1;
  logic [15:0] req_a1, req_b1, alu_a1, alu_b1;
  logic [14:0] alu_result1, rsp_hi1, rsp_lo1;

  logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3;
  logic [2:0]  req_op3, alu_command3;
  logic [15:0] req_a3, req_b3, alu_a3, alu_b3;
  logic [14:0] alu_result3, rsp_hi3, rsp_lo3;

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] op_count1, op_count3;
`endif

  int unsigned cmps = 0;
  int unsigned errs = 0;
  logic [30:0] sb[$];

  always #5 clk = ~clk;

  assign alu_result1 = {alu_command1, alu_a1[11:0]};
  assign alu_result3 = {alu_command3, alu_a3[11:0]};

  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
`ifdef ALU_SEQ_PERF_CNT_EN
    .op_count(op_count1),
`endif
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op1),
    .req_a(req_a1), .req_b(req_b1),
    .alu_command(alu_command1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_result(alu_result1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_hi(rsp_hi1), .rsp_lo(rsp_lo1), .rsp_err(rsp_err1)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (
`ifdef ALU_SEQ_PERF_CNT_EN
    .op_count(op_count3),
`endif
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
    .req_a(req_a3), .req_b(req_b3),
    .alu_command(alu_command3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_result(alu_result3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_hi(rsp_hi3), .rsp_lo(rsp_lo3), .rsp_err(rsp_err3)
  );

  function automatic logic [14:0] stub(input logic [2:0] c, input logic [15:0] a);
    logic [11:0] a_lo;
    a_lo = a[11:0];
    return {c, a_lo};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // One request on the SETTLE_CYCLES=1 instance; rsp_ready1 is held high.
  task automatic run1(input string name, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [2:0]  c1, c2;
    int          lat, n;
    logic [30:0] exp, got;
    c1 = 3'd0; c2 = 3'd0;
    case (op)
      3'd0, 3'd1, 3'd2: begin c1 = op; lat = 2; exp = {1'b0, 15'd0, stub(op, a)}; end
      3'd3: begin c1 = 3'd3; c2 = 3'd4; lat = 3; exp = {1'b0, stub(3'd3, a), stub(3'd4, a)}; end
      3'd4: begin
        if (b[15:1] == 15'd0) begin lat = 1; exp = {1'b1, 30'd0}; end
        else begin c1 = 3'd5; c2 = 3'd6; lat = 3; exp = {1'b0, stub(3'd5, a), stub(3'd6, a)}; end
      end
      default: begin lat = 1; exp = {1'b1, 30'd0}; end
    endcase
    @(negedge clk);
    check({name, ".req_ready"}, 32'(req_ready1), 32'd1);
    req_valid1 = 1'b1; req_op1 = op; req_a1 = a; req_b1 = b;
    sb.push_back(exp);
    @(negedge clk);
    req_valid1 = 1'b0;
    n = 1;
    check({name, ".cmd1"}, 32'(alu_command1), 32'(c1));
    while (!rsp_valid1 && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 2 && lat == 3) check({name, ".cmd2"}, 32'(alu_command1), 32'(c2));
    end
    check({name, ".latency"}, 32'(n), 32'(lat));
    got = {rsp_err1, rsp_hi1, rsp_lo1};
    if (sb.size() > 0) exp = sb.pop_front();
    check({name, ".rsp_hi"}, 32'(got[29:15]), 32'(exp[29:15]));
    check({name, ".rsp_lo"}, 32'(got[14:0]), 32'(exp[14:0]));
    check({name, ".rsp_err"}, 32'(got[30]), 32'(exp[30]));
  endtask

  initial begin
    logic [30:0] exp3;
    int          seen;
    reset = 1'b1;
    req_valid1 = 1'b0; req_op1 = '0; req_a1 = '0; req_b1 = '0; rsp_ready1 = 1'b1;
    req_valid3 = 1'b0; req_op3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst.req_ready", 32'(req_ready1), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid1), 32'd0);
    check("rst.rsp", {1'b0, rsp_err1, rsp_hi1, rsp_lo1}, 32'd0);
    check("rst.alu", {alu_command1, alu_a1[11:0], alu_b1}, 32'd0);

    run1("add", 3'd0, 16'h0123, 16'h0000);
    run1("mul", 3'd3, 16'h0ABC, 16'h0002);
    run1("div_b1", 3'd4, 16'h0777, 16'h0001);
    check("div_b1.alu_a_kept", 32'(alu_a1), 32'h0777);
    run1("op7", 3'd7, 16'h1234, 16'h5678);
    run1("sub", 3'd1, 16'hF00F, 16'h0001);
    run1("and", 3'd2, 16'h5A5A, 16'hFFFF);
    run1("div", 3'd4, 16'h0F05, 16'h0004);
    run1("div_b0", 3'd4, 16'h0005, 16'h0000);
    run1("add_after_err", 3'd0, 16'h0042, 16'h0000);

    // SETTLE_CYCLES=3 divide with a 5-cycle consumer stall
    exp3 = {1'b0, stub(3'd5, 16'h0005), stub(3'd6, 16'h0005)};
    @(negedge clk);
    req_valid3 = 1'b1; req_op3 = 3'd4; req_a3 = 16'h0005; req_b3 = 16'h0004;
    sb.push_back(exp3);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      req_valid3 = 1'b0;
      check($sformatf("s3.cmd%0d", i), 32'(alu_command3), (i <= 3) ? 32'd5 : 32'd6);
    end
    @(negedge clk);
    check("s3.rsp_valid_at_7", 32'(rsp_valid3), 32'd1);
    exp3 = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("s3.stall_rsp", {1'b0, rsp_err3, rsp_hi3, rsp_lo3}, {1'b0, exp3});
      check("s3.stall_ready", {30'd0, rsp_valid3, req_ready3}, 32'd2);
      check("s3.stall_cmd", 32'(alu_command3), 32'd0);
      if (i < 4) @(negedge clk);
    end
    rsp_ready3 = 1'b1;
    @(negedge clk);
    rsp_ready3 = 1'b0;
    check("s3.post_hs", {30'd0, rsp_valid3, req_ready3}, 32'd1);

    // Reset during ISSUE2 of a multiply
    @(negedge clk);
    req_valid1 = 1'b1; req_op1 = 3'd3; req_a1 = 16'h0321; req_b1 = 16'h0003;
    @(negedge clk);
    req_valid1 = 1'b0;
    @(negedge clk);
    check("rst2.in_issue2", 32'(alu_command1), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2.state", {29'd0, rsp_valid1, req_ready1, 1'b0}, 32'd2);
    check("rst2.cmd", 32'(alu_command1), 32'd0);
`ifdef ALU_SEQ_PERF_CNT_EN
    check("rst2.op_count", 32'(op_count1), 32'd0);
`endif
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid1) seen++;
    end
    check("rst2.no_response", 32'(seen), 32'd0);
    check("sb.drained", 32'(sb.size()), 32'd0);

`ifdef ALU_SEQ_PERF_CNT_EN
    // 65537 back-to-back ADD handshakes wrap the counter to 1
    seen = 0;
    req_op1 = 3'd0; req_a1 = 16'h0001; req_b1 = 16'h0000;
    req_valid1 = 1'b1;
    for (int cyc = 0; cyc < 250000; cyc++) begin
      @(negedge clk);
      if (rsp_valid1 && rsp_ready1) seen++;
      if (seen == 65537) break;
    end
    req_valid1 = 1'b0;
    check("wrap.handshakes", 32'(seen), 32'd65537);
    @(negedge clk);
    check("wrap.op_count", 32'(op_count1), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
